spi_board_master_tx: RTL and testbench

- SPI master transmitter that serializes a full N x N board of 8-bit characters out of the FPGA.
- Reads characters row-major from an external board RAM through a registered read port.
- Generates sclk, cs_n and sdo in a format the team's SPI board receiver accepts directly:
  - mode 0, MSB first, sdo changes on sclk falling edge and is sampled on sclk rising edge;
  - exactly 8*N*N sclk rising edges per frame.
- Counts the non-space characters sent.

---
 rtl/spi_board_pkg.sv | 14 +
 rtl/spi_board_master_tx_clk_div.sv | 32 +++
 rtl/spi_board_master_tx.sv | 143 ++++++++++++++
 tb/tb_spi_board_master_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_board_pkg.sv
// spi_board_pkg: shared board geometry, character constants and FSM encoding
// for the SPI board transmitter and receiver.
package spi_board_pkg;

    localparam int N      = 32;
    localparam int CHAR_W = 8;
    localparam logic [CHAR_W-1:0] SPACE_CHAR = 8'h20;

    typedef enum logic [1:0] {IDLE, PREP, SHIFT, TAIL} state_t;

    typedef logic [$clog2(N)-1:0] row_t;
    typedef logic [$clog2(N)-1:0] col_t;

endpackage

// File: rtl/spi_board_master_tx_clk_div.sv
// spi_clk_div: free-running sclk generator with half-period CLK_DIV.
// The strobes fire in the cycle whose closing clk edge toggles sclk.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_stb = wrap && !sclk;
    assign fall_stb = wrap && sclk;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            sclk <= sclk ^ wrap;
        end
    end

endmodule

// File: rtl/spi_board_master_tx.sv
// spi_board_master_tx: streams an N x N character board out over SPI mode 0,
// MSB first, with a one-ahead prefetch from a registered board RAM.
module spi_board_master_tx
    import spi_board_pkg::*;
#(
    parameter int N       = spi_board_pkg::N,
    parameter int CLK_DIV = 4,
    parameter logic [CHAR_W-1:0] SPACE_CHAR = spi_board_pkg::SPACE_CHAR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [$clog2(N)-1:0] rd_row,
    output logic [$clog2(N)-1:0] rd_col,
    input  logic [CHAR_W-1:0]    rd_data,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 sdo,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          nonspace_cnt
);
    localparam int AW = $clog2(N);
    localparam int IW = 2 * AW;
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [IW-1:0] LAST_CHAR = IW'(N * N - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLK_DIV - 1);
    localparam logic [AW-1:0] LAST_COL  = AW'(N - 1);

    state_t            state;
    logic [TW-1:0]     tick;
    logic [CHAR_W-1:0] shreg;
    logic [CHAR_W-1:0] next_buf;
    logic [2:0]        bit_cnt;
    logic [IW-1:0]     idx;
    logic [1:0]        pf;
    logic              end_byte;
    logic              end_frame;
    logic              rise_stb;
    logic              fall_stb;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .en       (state == SHIFT),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick         <= '0;
            rd_row       <= '0;
            rd_col       <= '0;
            cs_n         <= 1'b1;
            sdo          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            nonspace_cnt <= '0;
            shreg        <= '0;
            next_buf     <= '0;
            bit_cnt      <= '0;
            idx          <= '0;
            pf           <= '0;
            end_byte     <= 1'b0;
            end_frame    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // a start landing on the done cycle is dropped
                    if (start && !done) begin
                        state        <= PREP;
                        tick         <= '0;
                        nonspace_cnt <= '0;
                        rd_row       <= '0;
                        rd_col       <= '0;
                        cs_n         <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                PREP: begin
                    tick <= tick + 1'b1;
                    if (tick == LAST_TICK) begin
                        state        <= SHIFT;
                        tick         <= '0;
                        shreg        <= rd_data;
                        sdo          <= rd_data[7];
                        nonspace_cnt <= nonspace_cnt + {15'd0, rd_data != SPACE_CHAR};
                        bit_cnt      <= '0;
                        idx          <= '0;
                        pf           <= 2'd1;
                    end
                end
                SHIFT: begin
                    // prefetch: address on pf=1, RAM registers on pf=2, capture on pf=3
                    if (pf == 2'd1) begin
                        rd_col <= (rd_col == LAST_COL) ? '0 : rd_col + 1'b1;
                        rd_row <= (rd_col == LAST_COL) ? rd_row + 1'b1 : rd_row;
                    end
                    if (pf == 2'd3)
                        next_buf <= rd_data;
                    pf <= (pf == 2'd0) ? 2'd0 : pf + 1'b1;
                    if (rise_stb) begin
                        end_byte  <= bit_cnt == 3'd7;
                        end_frame <= idx == LAST_CHAR;
                    end
                    if (fall_stb) begin
                        if (!end_byte) begin
                            shreg   <= {shreg[6:0], 1'b0};
                            sdo     <= shreg[6];
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (end_frame) begin
                            state <= TAIL;
                            tick  <= '0;
                            cs_n  <= 1'b1;
                            sdo   <= 1'b0;
                        end else begin
                            shreg        <= next_buf;
                            sdo          <= next_buf[7];
                            bit_cnt      <= '0;
                            idx          <= idx + 1'b1;
                            nonspace_cnt <= nonspace_cnt + {15'd0, next_buf != SPACE_CHAR};
                            pf           <= (idx + 1'b1 == LAST_CHAR) ? 2'd0 : 2'd1;
                        end
                    end
                end
                TAIL: begin
                    tick <= tick + 1'b1;
                    if (tick == LAST_TICK) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_board_master_tx.sv
// tb_spi_board_master_tx: three transmitter instances (N=2/4/32) against
// registered RAM models, with an SPI-side receiver monitor per instance.
module tb_spi_board_master_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, start_v, sclk_v, cs_v, sdo_v, busy_v, done_v;
    logic [15:0] ns0, ns1, ns2;
    logic [0:0] r2, c2;
    logic [1:0] r4, c4;
    logic [4:0] r32, c32;
    logic [7:0] d2, d4, d32;
    logic [7:0] mem2 [4];
    logic [7:0] mem4 [16];
    logic [7:0] mem32 [1024];

    always @(posedge clk) begin
        d2  <= mem2[{r2, c2}];
        d4  <= mem4[{r4, c4}];
        d32 <= mem32[{r32, c32}];
    end

    spi_board_master_tx #(.N(2), .CLK_DIV(2)) dut2 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .rd_row(r2), .rd_col(c2), .rd_data(d2),
        .sclk(sclk_v[0]), .cs_n(cs_v[0]), .sdo(sdo_v[0]), .busy(busy_v[0]), .done(done_v[0]), .nonspace_cnt(ns0));
    spi_board_master_tx #(.N(4), .CLK_DIV(3)) dut4 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .rd_row(r4), .rd_col(c4), .rd_data(d4),
        .sclk(sclk_v[1]), .cs_n(cs_v[1]), .sdo(sdo_v[1]), .busy(busy_v[1]), .done(done_v[1]), .nonspace_cnt(ns1));
    spi_board_master_tx dut32 (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .rd_row(r32), .rd_col(c32), .rd_data(d32),
        .sclk(sclk_v[2]), .cs_n(cs_v[2]), .sdo(sdo_v[2]), .busy(busy_v[2]), .done(done_v[2]), .nonspace_cnt(ns2));

    int checks = 0;
    int errors = 0;

    // receiver-side monitor state, one slot per instance
    int cd [3] = '{2, 3, 4};
    int frames [3] = '{0, 0, 0};
    int dones [3] = '{0, 0, 0};
    int rises [3] = '{0, 0, 0};
    int bad [3] = '{0, 0, 0};
    int nb [3] = '{0, 0, 0};
    int sdo_age [3] = '{0, 0, 0};
    int rise_age [3] = '{1000, 1000, 1000};
    int cs_age [3] = '{0, 0, 0};
    logic ps [3];
    logic pcs [3];
    logic psdo [3];
    logic [7:0] sh [3];
    logic [7:0] bq [3][$];
    logic [3:0] alog [$];
    logic [3:0] plast;
    logic pbusy4 = 1'b0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_v[k]) begin
                ps[k] = 1'b0; pcs[k] = 1'b1; psdo[k] = 1'b0; rise_age[k] = 1000;
            end else begin
                if (!cs_v[k] && pcs[k]) begin
                    frames[k]++; rises[k] = 0; nb[k] = 0; bq[k].delete(); cs_age[k] = 0;
                end
                if (sdo_v[k] !== psdo[k]) begin
                    if (rise_age[k] < cd[k]) bad[k]++;
                    sdo_age[k] = 0;
                end
                if (sclk_v[k] && !ps[k]) begin
                    if (sdo_age[k] < cd[k] || cs_v[k] || (rises[k] == 0 && cs_age[k] < cd[k])) bad[k]++;
                    rises[k]++;
                    sh[k] = {sh[k][6:0], sdo_v[k]};
                    nb[k]++;
                    if (nb[k] == 8) begin bq[k].push_back(sh[k]); nb[k] = 0; end
                    rise_age[k] = 0;
                end
                if (cs_v[k] && !pcs[k] && (rise_age[k] < cd[k] || sclk_v[k])) bad[k]++;
                if (done_v[k]) dones[k]++;
                ps[k] = sclk_v[k]; pcs[k] = cs_v[k]; psdo[k] = sdo_v[k];
                if (sdo_age[k] < 1000000) sdo_age[k]++;
                if (rise_age[k] < 1000000) rise_age[k]++;
                if (cs_age[k] < 1000000) cs_age[k]++;
            end
        end
        if (!rst_v[1]) begin
            if (busy_v[1] && !pbusy4) begin alog.delete(); alog.push_back({r4, c4}); end
            else if (busy_v[1] && {r4, c4} != plast) alog.push_back({r4, c4});
            plast = {r4, c4};
            pbusy4 = busy_v[1];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int k);
        @(negedge clk); start_v[k] = 1'b1;
        @(negedge clk); start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output int lat);
        int n = 0;
        while (!done_v[k] && n < budget) begin @(negedge clk); n++; end
        if (!done_v[k]) begin
            checks++; errors++;
            $display("FAIL timeout inst %0d got no done want done within %0d", k, budget);
        end
        lat = n;
    endtask

    function automatic logic [31:0] pack2();
        logic [31:0] v = '0;
        for (int i = 0; i < bq[0].size() && i < 4; i++) v = {v[23:0], bq[0][i]};
        return v;
    endfunction

    typedef struct {
        logic [31:0] board;
        int          ns;
        int          lat;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int lat, f0, d0, ok;
        logic [31:0] first;
        vecs[0] = '{32'h41424344, 4, 132};
        vecs[1] = '{32'h20202020, 0, 132};
        vecs[2] = '{32'h20FF0020, 2, 132};
        vecs[3] = '{32'h8001207E, 3, 132};
        for (int i = 0; i < 16; i++) mem4[i] = 8'h20;
        mem4[0] = 8'h4A; mem4[7] = 8'h4A; mem4[15] = 8'h41;
        for (int i = 0; i < 1024; i++) mem32[i] = i[7:0];
        for (int i = 0; i < 4; i++) mem2[i] = 8'h00;
        start_v = '0;
        rst_v = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", sclk_v[0], 0);
        chk("rst_cs_n", cs_v[0], 1);
        chk("rst_sdo", sdo_v[0], 0);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        chk("rst_nonspace", ns0, 0);
        chk("rst_addr", {r32, c32}, 0);
        chk("rst_cs_all", cs_v, 3'b111);
        rst_v = '0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) mem2[i] = vecs[v].board[31 - 8*i -: 8];
            d0 = dones[0];
            pulse(0);
            wait_done(0, 400, lat);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_rises", v), rises[0], 32);
            chk($sformatf("v%0d_nbytes", v), bq[0].size(), 4);
            chk($sformatf("v%0d_bytes", v), pack2(), vecs[v].board);
            chk($sformatf("v%0d_nonspace", v), ns0, vecs[v].ns);
            @(negedge clk);
            chk($sformatf("v%0d_done_once", v), dones[0] - d0, 1);
            chk($sformatf("v%0d_idle", v), {busy_v[0], cs_v[0], sclk_v[0]}, 3'b010);
        end

        pulse(1);
        wait_done(1, 1000, lat);
        chk("n4_latency", lat, 774);
        chk("n4_nonspace", ns1, 3);
        chk("n4_addr_count", alog.size(), 16);
        ok = 0;
        for (int i = 0; i < alog.size(); i++) if (alog[i] == i[3:0]) ok++;
        chk("n4_addr_order", ok, 16);
        ok = 0;
        for (int i = 0; i < bq[1].size(); i++) if (bq[1][i] == mem4[i]) ok++;
        chk("n4_bytes", ok, 16);

        for (int i = 0; i < 4; i++) mem2[i] = vecs[0].board[31 - 8*i -: 8];
        f0 = frames[0];
        @(negedge clk); start_v[0] = 1'b1;
        wait_done(0, 400, lat);
        @(negedge clk); start_v[0] = 1'b0;
        chk("spam_frames", frames[0] - f0, 1);
        chk("spam_done_cycle_ignored", busy_v[0], 0);
        first = pack2();
        chk("spam_bytes", first, vecs[0].board);
        pulse(0);
        wait_done(0, 400, lat);
        chk("second_frame_latency", lat, 132);
        chk("second_frame_bytes", pack2(), first);
        chk("second_frame_count", frames[0] - f0, 2);

        d0 = dones[2];
        pulse(2);
        wait_done(2, 70000, lat);
        chk("n32_latency", lat, 65544);
        chk("n32_rises", rises[2], 8192);
        chk("n32_nbytes", bq[2].size(), 1024);
        ok = 0;
        for (int i = 0; i < bq[2].size(); i++) if (bq[2][i] == i[7:0]) ok++;
        chk("n32_bytes", ok, 1024);
        chk("n32_nonspace", ns2, 1020);
        @(negedge clk);
        chk("n32_done_once", dones[2] - d0, 1);

        for (int k = 0; k < 3; k++) chk($sformatf("timing_inst%0d", k), bad[k], 0);

        d0 = dones[0];
        pulse(0);
        repeat (12) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        chk("abort_cs_n", cs_v[0], 1);
        chk("abort_sclk", sclk_v[0], 0);
        chk("abort_busy", busy_v[0], 0);
        rst_v[0] = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_done", dones[0] - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
